rv_dm_sba_engine: RTL and testbench
===================================

Name: rv_dm_sba_engine

Overview:
Parametrised system-bus-access engine for the debug module; successor to the fixed 32-bit SBA unit. It sits between the DM CSR block and a req/gnt host-bus adapter. Over the single-width version it adds: configurable data and address width, all sbaccess sizes up to BusWidth, a bus error input, a response timeout, and lifecycle gating of bus access.

Parameters:
BusWidth, 32, data bus width in bits; 32 or 64.
AddrWidth, 32, system address width in bits; 32..64.
TimeoutCycles, 1024, cycles to wait for a response after grant before flagging a timeout; must be >= 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
dmactive_i  in  1  DM active; low forces the engine idle
debug_en_i  in  1  decoded lifecycle debug enable; low blocks all bus access
sbaddress_i  in  AddrWidth  address written by the CSR block
sbaddress_write_valid_i  in  1  sbaddress write strobe
sbaddress_o  out  AddrWidth  current address, including autoincrement
sbreadonaddr_i / sbreadondata_i / sbautoincrement_i  in  1 each  sbcs mode bits
sbaccess_i  in  3  access size code; size is 2^sbaccess bytes
sbdata_i  in  BusWidth  write data
sbdata_write_valid_i  in  1  sbdata write strobe; triggers a write
sbdata_read_valid_i  in  1  sbdata read strobe
sbdata_o  out  BusWidth  read data, right-aligned and zero-extended
sbdata_valid_o  out  1  one-cycle pulse when sbdata_o is updated
sbbusy_o  out  1  access in flight
sberror_valid_o  out  1  one-cycle error pulse
sberror_o  out  3  error code; valid with the pulse
master_req_o  out  1  bus request
master_add_o  out  AddrWidth  byte address
master_we_o  out  1  write enable
master_wdata_o  out  BusWidth  lane-positioned write data
master_be_o  out  BusWidth/8  byte enables
master_gnt_i  in  1  request granted
master_r_valid_i  in  1  response valid; returned for reads and writes
master_r_rdata_i  in  BusWidth  read data
master_r_err_i  in  1  bus error on response

Behaviour:
- Reset: every output is 0. FSM in IDLE; address, data and timeout counter are 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ on a trigger. The trigger is latched: address, we, size and wdata.
- Trigger sources:
  - sbaddress_write_valid_i & sbreadonaddr_i -> read at the new address.
  - sbdata_write_valid_i -> write.
  - sbdata_read_valid_i & sbreadondata_i -> read.
- sbaddress_write_valid_i always loads the address register, even when it does not trigger.
- Checks are made in the trigger cycle; any failure pulses sberror the next cycle, with no bus request and the engine staying IDLE. Priority, highest first:
  - !debug_en_i -> code 7.
  - 2^sbaccess*8 > BusWidth -> code 4.
  - address not aligned to the size -> code 3.
- Triggers arriving while sbbusy_o is high are ignored; busy-error is tracked in the CSRs.
- Latency: trigger at cycle N -> master_req_o=1 at N+1. sbbusy_o is high from N+1 until the completion cycle.
- REQ:
  - master_req_o is held with stable add/we/wdata/be until master_gnt_i.
  - On grant: go to WAIT, deassert req, clear the counter.
  - A response in the same cycle as the grant is legal and is handled as in WAIT.
- Byte lanes: off = addr[log2(BusWidth/8)-1:0].
  - master_be_o = ((1<<2^sbaccess)-1) << off.
  - master_wdata_o = sbdata_i << 8*off.
  - master_add_o = the full byte address.
- WAIT on master_r_valid_i:
  - Read: sbdata_o <= (rdata >> 8*off), masked to the size; sbdata_valid_o pulses.
  - If master_r_err_i: code 7 pulse, sbdata_o unchanged, no autoincrement.
  - Then -> IDLE; sbbusy_o falls the next cycle.
- Timeout: the counter increments each WAIT cycle. When it reaches TimeoutCycles-1 without a response: code 1 pulse -> IDLE. A later stray master_r_valid_i in IDLE is ignored.
- Autoincrement: on successful completion with sbautoincrement_i, address += 2^sbaccess, wrapping modulo 2^AddrWidth.
- Simultaneous sbaddress write and completion: the CSR write wins over the autoincrement.
- dmactive_i low:
  - FSM -> IDLE and master_req_o deasserts next cycle.
  - Counter, address and sbdata_o clear.
  - No error pulse.
  - In-flight responses are ignored.
- Error codes: 1 timeout, 3 alignment, 4 size, 7 other. Codes 0, 2, 5 and 6 are never produced.

Test Plan:
- BusWidth=32: write addr 0x1000_0002, sbaccess=1, sbdata=0xABCD -> be=0b1100, wdata=0xABCD_0000, add=0x1000_0002; no error.
- BusWidth=64: readonaddr, addr 0x8, sbaccess=3, autoincrement, rdata=0x1122_3344_5566_7788 -> sbdata_o equals rdata, sbaddress_o=0x10, busy low after completion.
- sbaccess=3 on BusWidth=32 -> sberror 4, no master_req_o. Addr 0x3 with sbaccess=2 -> sberror 3.
- debug_en_i=0, write trigger -> sberror 7, master_req_o stays 0 throughout.
- TimeoutCycles=8: grant, then no r_valid for 8 cycles -> sberror 1 after 7 WAIT cycles, busy falls; late r_valid is ignored.
- dmactive_i dropped mid-WAIT -> busy and req clear next cycle, no error pulse; address wrap 0xFFFF_FFFC + 4 -> 0x0.

Source files
------------

// File: rtl/rv_dm_sba_engine.sv
// System bus access engine: turns DM sbaddress/sbdata CSR activity into sized,
// lane-positioned req/gnt bus transactions with lifecycle, alignment and timeout checks.
module rv_dm_sba_engine #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dmactive_i,
    input  logic                    debug_en_i,
    input  logic [AddrWidth-1:0]    sbaddress_i,
    input  logic                    sbaddress_write_valid_i,
    output logic [AddrWidth-1:0]    sbaddress_o,
    input  logic                    sbreadonaddr_i,
    input  logic                    sbreadondata_i,
    input  logic                    sbautoincrement_i,
    input  logic [2:0]              sbaccess_i,
    input  logic [BusWidth-1:0]     sbdata_i,
    input  logic                    sbdata_write_valid_i,
    input  logic                    sbdata_read_valid_i,
    output logic [BusWidth-1:0]     sbdata_o,
    output logic                    sbdata_valid_o,
    output logic                    sbbusy_o,
    output logic                    sberror_valid_o,
    output logic [2:0]              sberror_o,
    output logic                    master_req_o,
    output logic [AddrWidth-1:0]    master_add_o,
    output logic                    master_we_o,
    output logic [BusWidth-1:0]     master_wdata_o,
    output logic [BusWidth/8-1:0]   master_be_o,
    input  logic                    master_gnt_i,
    input  logic                    master_r_valid_i,
    input  logic [BusWidth-1:0]     master_r_rdata_i,
    input  logic                    master_r_err_i
);
    localparam int unsigned NumBytes = BusWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned CntW     = $clog2(TimeoutCycles) + 1;
    localparam logic [2:0]  MaxSize  = 3'(OffW);

    localparam logic [2:0] ErrTimeout = 3'd1;
    localparam logic [2:0] ErrAlign   = 3'd3;
    localparam logic [2:0] ErrSize    = 3'd4;
    localparam logic [2:0] ErrOther   = 3'd7;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    state_e state_q, state_d;

    logic [AddrWidth-1:0] addr_q, req_addr_q, trig_addr;
    logic                 we_q;
    logic [2:0]           size_q;
    logic [BusWidth-1:0]  wdata_q, sbdata_q;
    logic [CntW-1:0]      cnt_q;
    logic                 rvalid_q, err_valid_q;
    logic [2:0]           err_code_q;

    logic                 busy, trigger, trig_we, trigger_ok;
    logic                 chk_err, size_bad, misaligned;
    logic [2:0]           chk_code;
    logic [6:0]           align_mask;
    logic                 rsp_seen, timeout;
    logic [OffW-1:0]      off;
    logic [NumBytes-1:0]  size_be;
    logic [BusWidth-1:0]  rdata_mask, rdata_aligned;

    function automatic logic [NumBytes-1:0] size_bytes(input logic [2:0] size);
        logic [NumBytes-1:0] m;
        m = '0;
        for (int i = 0; i < NumBytes; i++) m[i] = (i < (1 << size));
        return m;
    endfunction

    // Trigger decode and the three ordered checks, all evaluated in the trigger cycle
    assign busy       = (state_q != IDLE);
    assign trigger    = dmactive_i & ~busy &
                        ((sbaddress_write_valid_i & sbreadonaddr_i) | sbdata_write_valid_i |
                         (sbdata_read_valid_i & sbreadondata_i));
    assign trig_we    = sbdata_write_valid_i;
    assign trig_addr  = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign size_bad   = (sbaccess_i > MaxSize);
    assign align_mask = (7'(1) << sbaccess_i) - 7'd1;
    assign misaligned = |(trig_addr[6:0] & align_mask);

    always_comb begin
        chk_err  = 1'b1;
        chk_code = ErrOther;
        if (!debug_en_i)     chk_code = ErrOther;
        else if (size_bad)   chk_code = ErrSize;
        else if (misaligned) chk_code = ErrAlign;
        else                 chk_err  = 1'b0;
    end

    assign trigger_ok = trigger & ~chk_err;

    // A response is accepted in WAIT, or in REQ when it arrives alongside the grant
    assign rsp_seen = master_r_valid_i &
                      ((state_q == WAIT) | ((state_q == REQ) & master_gnt_i));
    assign timeout  = (state_q == WAIT) & ~master_r_valid_i &
                      (cnt_q == CntW'(TimeoutCycles - 2));

    assign off     = req_addr_q[OffW-1:0];
    assign size_be = size_bytes(size_q);

    always_comb begin
        rdata_mask = '0;
        for (int i = 0; i < NumBytes; i++) rdata_mask[8*i +: 8] = {8{size_be[i]}};
        rdata_aligned = (master_r_rdata_i >> {off, 3'b000}) & rdata_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger_ok) state_d = REQ;
            REQ:     if (master_gnt_i) state_d = master_r_valid_i ? IDLE : WAIT;
            WAIT:    if (master_r_valid_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!dmactive_i) state_d = IDLE;
    end

    always_comb begin
        sbbusy_o       = busy;
        master_req_o   = 1'b0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        if (state_q == REQ) begin
            master_req_o   = 1'b1;
            master_add_o   = req_addr_q;
            master_we_o    = we_q;
            master_wdata_o = wdata_q << {off, 3'b000};
            master_be_o    = size_be << off;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            req_addr_q  <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            wdata_q     <= '0;
            sbdata_q    <= '0;
            cnt_q       <= '0;
            rvalid_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            rvalid_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            if (!dmactive_i) begin
                addr_q   <= '0;
                sbdata_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (trigger && chk_err) begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= chk_code;
                end
                if (trigger_ok) begin
                    req_addr_q <= trig_addr;
                    we_q       <= trig_we;
                    size_q     <= sbaccess_i;
                    wdata_q    <= sbdata_i;
                end
                if (state_q == REQ && master_gnt_i) cnt_q <= '0;
                else if (state_q == WAIT)           cnt_q <= cnt_q + CntW'(1);
                if (rsp_seen) begin
                    if (master_r_err_i) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ErrOther;
                    end else if (!we_q) begin
                        sbdata_q <= rdata_aligned;
                        rvalid_q <= 1'b1;
                    end
                end
                if (timeout) begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= ErrTimeout;
                end
                // A CSR address write beats the autoincrement of a completing access
                if (sbaddress_write_valid_i)
                    addr_q <= sbaddress_i;
                else if (rsp_seen && !master_r_err_i && sbautoincrement_i)
                    addr_q <= addr_q + (AddrWidth'(1) << size_q);
            end
        end
    end

    assign sbaddress_o     = addr_q;
    assign sbdata_o        = sbdata_q;
    assign sbdata_valid_o  = rvalid_q;
    assign sberror_valid_o = err_valid_q;
    assign sberror_o       = err_code_q;

endmodule

// File: tb/tb_rv_dm_sba_engine.sv
// Directed bench for rv_dm_sba_engine: a 32-bit and a 64-bit instance share the CSR
// inputs, while strobes and bus responses are steered to one instance via sel64.
module tb_rv_dm_sba_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel64 = 1'b0;
    logic        dmactive = 1'b1, debug_en = 1'b1;
    logic [31:0] sbaddress = '0;
    logic        awv = 1'b0, dwv = 1'b0, drv = 1'b0;
    logic        rdonaddr = 1'b0, rdondata = 1'b0, autoinc = 1'b0;
    logic [2:0]  sbaccess = '0;
    logic [63:0] sbdata = '0, rdata = '0;
    logic        gnt = 1'b0, rvalid = 1'b0, rerr = 1'b0;

    logic awv32, dwv32, drv32, gnt32, rv32, awv64, dwv64, drv64, gnt64, rv64;
    assign awv32 = awv & ~sel64;   assign awv64 = awv & sel64;
    assign dwv32 = dwv & ~sel64;   assign dwv64 = dwv & sel64;
    assign drv32 = drv & ~sel64;   assign drv64 = drv & sel64;
    assign gnt32 = gnt & ~sel64;   assign gnt64 = gnt & sel64;
    assign rv32  = rvalid & ~sel64; assign rv64 = rvalid & sel64;

    logic [31:0] a32_addr, a32_add, a32_data, a32_wdata;
    logic        a32_dv, a32_busy, a32_ev, a32_req, a32_we;
    logic [2:0]  a32_err;
    logic [3:0]  a32_be;
    logic [31:0] a64_addr, a64_add;
    logic [63:0] a64_data, a64_wdata;
    logic        a64_dv, a64_busy, a64_ev, a64_req, a64_we;
    logic [2:0]  a64_err;
    logic [7:0]  a64_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_dm_sba_engine #(.BusWidth(32), .AddrWidth(32), .TimeoutCycles(8)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .debug_en_i(debug_en),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(awv32), .sbaddress_o(a32_addr),
        .sbreadonaddr_i(rdonaddr), .sbreadondata_i(rdondata), .sbautoincrement_i(autoinc),
        .sbaccess_i(sbaccess), .sbdata_i(sbdata[31:0]), .sbdata_write_valid_i(dwv32),
        .sbdata_read_valid_i(drv32), .sbdata_o(a32_data), .sbdata_valid_o(a32_dv),
        .sbbusy_o(a32_busy), .sberror_valid_o(a32_ev), .sberror_o(a32_err),
        .master_req_o(a32_req), .master_add_o(a32_add), .master_we_o(a32_we),
        .master_wdata_o(a32_wdata), .master_be_o(a32_be), .master_gnt_i(gnt32),
        .master_r_valid_i(rv32), .master_r_rdata_i(rdata[31:0]), .master_r_err_i(rerr));

    rv_dm_sba_engine #(.BusWidth(64), .AddrWidth(32), .TimeoutCycles(8)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .debug_en_i(debug_en),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(awv64), .sbaddress_o(a64_addr),
        .sbreadonaddr_i(rdonaddr), .sbreadondata_i(rdondata), .sbautoincrement_i(autoinc),
        .sbaccess_i(sbaccess), .sbdata_i(sbdata), .sbdata_write_valid_i(dwv64),
        .sbdata_read_valid_i(drv64), .sbdata_o(a64_data), .sbdata_valid_o(a64_dv),
        .sbbusy_o(a64_busy), .sberror_valid_o(a64_ev), .sberror_o(a64_err),
        .master_req_o(a64_req), .master_add_o(a64_add), .master_we_o(a64_we),
        .master_wdata_o(a64_wdata), .master_be_o(a64_be), .master_gnt_i(gnt64),
        .master_r_valid_i(rv64), .master_r_rdata_i(rdata), .master_r_err_i(rerr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_busy", a32_busy, 0);   chk("rst_req", a32_req, 0);
        chk("rst_addr", a32_addr, 0);   chk("rst_data", a32_data, 0);
        chk("rst_err", {a32_ev, a32_err}, 0); chk("rst_be", a32_be, 0);
        chk("rst64_out", {a64_req, a64_busy, a64_dv, a64_ev}, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 32-bit halfword write at offset 2
        sbaddress = 32'h1000_0002; awv = 1; step(); awv = 0;
        chk("addr_load", a32_addr, 32'h1000_0002);
        chk("addr_no_trig", a32_req, 0);
        sbaccess = 1; sbdata = 64'hABCD; dwv = 1; step(); dwv = 0;
        chk("wr_req", a32_req, 1);      chk("wr_be", a32_be, 4'b1100);
        chk("wr_wdata", a32_wdata, 32'hABCD_0000); chk("wr_add", a32_add, 32'h1000_0002);
        chk("wr_we", a32_we, 1);        chk("wr_busy", a32_busy, 1);
        chk("wr_noerr", a32_ev, 0);
        sbaccess = 3; dwv = 1; step(); dwv = 0;   // ignored while busy
        chk("wr_hold_req", a32_req, 1); chk("wr_hold_be", a32_be, 4'b1100);
        chk("busy_ignore", a32_ev, 0);
        gnt = 1; step(); gnt = 0;
        chk("wr_gnt_req", a32_req, 0);  chk("wr_wait_busy", a32_busy, 1);
        rvalid = 1; step(); rvalid = 0;
        chk("wr_done_busy", a32_busy, 0); chk("wr_done_dv", a32_dv, 0);
        chk("wr_done_ev", a32_ev, 0);   chk("wr_addr_keep", a32_addr, 32'h1000_0002);

        // check errors
        sbaccess = 3; dwv = 1; step(); dwv = 0;
        chk("size_err", {a32_ev, a32_err}, {1'b1, 3'd4}); chk("size_noreq", a32_req, 0);
        step();
        chk("err_pulse_end", a32_ev, 0);
        sbaddress = 32'h3; sbaccess = 2; rdonaddr = 1; awv = 1; step(); awv = 0; rdonaddr = 0;
        chk("align_err", {a32_ev, a32_err}, {1'b1, 3'd3}); chk("align_noreq", a32_req, 0);
        chk("align_addr", a32_addr, 32'h3);
        debug_en = 0; sbaccess = 3; dwv = 1; step(); dwv = 0;
        chk("dbg_err", {a32_ev, a32_err}, {1'b1, 3'd7}); chk("dbg_noreq", a32_req, 0);
        step();
        chk("dbg_noreq2", a32_req, 0);
        debug_en = 1;

        // read on address with grant+response in one cycle, autoincrement wraps
        sbaddress = 32'hFFFF_FFFC; sbaccess = 2; rdonaddr = 1; autoinc = 1; awv = 1;
        step(); awv = 0; rdonaddr = 0;
        chk("rd_req", {a32_req, a32_we}, 2'b10); chk("rd_add", a32_add, 32'hFFFF_FFFC);
        chk("rd_be", a32_be, 4'hF);
        gnt = 1; rvalid = 1; rdata = 64'hDEAD_BEEF; step(); gnt = 0; rvalid = 0;
        chk("rd_data", a32_data, 32'hDEAD_BEEF); chk("rd_dv", a32_dv, 1);
        chk("rd_wrap", a32_addr, 32'h0);   chk("rd_busy", a32_busy, 0);
        step();
        chk("rd_dv_pulse", a32_dv, 0);

        // byte read on data at offset 1
        autoinc = 0; sbaddress = 32'h5; awv = 1; step(); awv = 0;
        sbaccess = 0; rdondata = 1; drv = 1; step(); drv = 0;
        chk("byte_add", a32_add, 32'h5); chk("byte_be", a32_be, 4'b0010);
        gnt = 1; step(); gnt = 0;
        rvalid = 1; rdata = 64'h1122_3344; step(); rvalid = 0;
        chk("byte_data", a32_data, 32'h33); chk("byte_dv", a32_dv, 1);

        // bus error: no data update, no autoincrement
        autoinc = 1; dwv = 1; step(); dwv = 0;
        gnt = 1; rvalid = 1; rerr = 1; step(); gnt = 0; rvalid = 0; rerr = 0;
        chk("berr", {a32_ev, a32_err}, {1'b1, 3'd7}); chk("berr_data", a32_data, 32'h33);
        chk("berr_addr", a32_addr, 32'h5); chk("berr_busy", a32_busy, 0);
        autoinc = 0;

        // timeout: 7 WAIT cycles then code 1
        drv = 1; step(); drv = 0;
        gnt = 1; step(); gnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("to_wait", {a32_busy, a32_ev}, 2'b10);
        end
        step();
        chk("to_err", {a32_ev, a32_err}, {1'b1, 3'd1}); chk("to_busy", a32_busy, 0);
        rvalid = 1; rdata = 64'hFFFF_FFFF; step(); rvalid = 0;
        chk("late_dv", a32_dv, 0); chk("late_data", a32_data, 32'h33);
        chk("late_ev", a32_ev, 0);

        // dmactive drop mid-WAIT
        drv = 1; step(); drv = 0;
        gnt = 1; step(); gnt = 0;
        chk("dm_wait", a32_busy, 1);
        dmactive = 0; step();
        chk("dm_clear", {a32_busy, a32_req, a32_ev}, 0);
        chk("dm_addr", a32_addr, 0); chk("dm_data", a32_data, 0);
        rvalid = 1; step(); rvalid = 0;
        chk("dm_ignore", {a32_dv, a32_ev}, 0);
        dmactive = 1; step();

        // 64-bit instance
        sel64 = 1;
        sbaddress = 32'h8; sbaccess = 3; rdonaddr = 1; autoinc = 1; awv = 1;
        step(); awv = 0; rdonaddr = 0;
        chk("r64_req", a64_req, 1); chk("r64_add", a64_add, 32'h8); chk("r64_be", a64_be, 8'hFF);
        gnt = 1; step(); gnt = 0;
        rvalid = 1; rdata = 64'h1122_3344_5566_7788; step(); rvalid = 0;
        chk("r64_data", a64_data, 64'h1122_3344_5566_7788); chk("r64_dv", a64_dv, 1);
        chk("r64_addr", a64_addr, 32'h10); chk("r64_busy", a64_busy, 0);
        chk("r32_quiet", a32_req, 0);
        sbaddress = 32'h16; awv = 1; step(); awv = 0;
        sbaccess = 1; sbdata = 64'hBEEF; dwv = 1; step(); dwv = 0;
        chk("w64_be", a64_be, 8'hC0); chk("w64_wdata", a64_wdata, 64'hBEEF_0000_0000_0000);
        chk("w64_we", a64_we, 1);
        gnt = 1; rvalid = 1; step(); gnt = 0; rvalid = 0;
        chk("w64_addr", a64_addr, 32'h18); chk("w64_dv", a64_dv, 0);
        sbaccess = 4; dwv = 1; step(); dwv = 0;
        chk("s64_err", {a64_ev, a64_err}, {1'b1, 3'd4}); chk("s64_noreq", a64_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
